// File: rtl/note_scheduler.sv
// Falling-note game sequencer: converts diff_speed into a row-advance tick,
// spawns LFSR-driven notes into a LANES x DEPTH grid and judges strike-row hits.
module note_scheduler #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int MAX_MISS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mode,
  input  logic [22:0]            diff_speed,
  input  logic [1:0]             level,
  input  logic [LANES-1:0]       hit,
  output logic                   tick,
  output logic [LANES*DEPTH-1:0] grid,
  output logic [7:0]             score,
  output logic [7:0]             misses,
  output logic                   game_over
);

  localparam logic [2:0] MODE_PLAY  = 3'd1;
  localparam logic [2:0] MODE_PAUSE = 3'd2;
  localparam logic [7:0] MISS_CAP   = 8'(MAX_MISS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_e;

  state_e                       state_q, state_d;
  logic [22:0]                  cnt_q, cnt_d;
  logic                         tick_q, tick_d;
  logic [DEPTH-1:0][LANES-1:0]  grid_q, grid_d;
  logic [7:0]                   lfsr_q, lfsr_d;
  logic [7:0]                   score_q, score_d;
  logic [7:0]                   misses_q, misses_d;

  logic                         active, wrap, spawn_en, fb;
  logic [LANES-1:0]             strike, good, bad, cleared, escaped, spawn;
  logic [9:0]                   score_sum, miss_sum;
  int                           lane_idx;

  function automatic logic [7:0] popcnt(input logic [LANES-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (mode == MODE_PLAY) state_d = S_RUN;
      S_RUN: begin
        if (misses_q == MISS_CAP)       state_d = S_OVER;
        else if (mode == MODE_PAUSE)    state_d = S_PAUSE;
        else if (mode != MODE_PLAY)     state_d = S_IDLE;
      end
      S_PAUSE: begin
        if (mode == MODE_PLAY)          state_d = S_RUN;
        else if (mode != MODE_PAUSE)    state_d = S_IDLE;
      end
      S_OVER:  if (mode != MODE_PLAY && mode != MODE_PAUSE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only cycles that stay in RUN advance play; leaving RUN freezes that cycle.
  assign active   = (state_q == S_RUN) && (state_d == S_RUN);
  assign wrap     = (cnt_q >= diff_speed);
  assign strike   = grid_q[DEPTH-1];
  assign good     = hit & strike;
  assign bad      = hit & ~strike;
  assign cleared  = strike & ~hit;
  assign escaped  = wrap ? cleared : '0;
  assign fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign spawn_en = (lfsr_q[7:5] < ({1'b0, level} + 3'd2));
  assign lane_idx = int'(lfsr_q[1:0]) % LANES;

  always_comb begin
    for (int l = 0; l < LANES; l++) spawn[l] = spawn_en && (lane_idx == l);
  end

  assign score_sum = {2'b00, score_q} + 10'(popcnt(good));
  assign miss_sum  = {2'b00, misses_q} + 10'(popcnt(bad)) + 10'(popcnt(escaped));

  always_comb begin
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    grid_d   = grid_q;
    lfsr_d   = lfsr_q;
    score_d  = score_q;
    misses_d = misses_q;

    if (active) begin
      tick_d   = wrap;
      cnt_d    = wrap ? '0 : cnt_q + 23'd1;
      score_d  = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];
      misses_d = (miss_sum >= 10'(MAX_MISS)) ? MISS_CAP : miss_sum[7:0];
      if (wrap) begin
        for (int r = DEPTH-1; r > 0; r--) grid_d[r] = grid_q[r-1];
        grid_d[0] = spawn;
        lfsr_d    = {lfsr_q[6:0], fb};
      end else begin
        grid_d[DEPTH-1] = cleared;
      end
    end

    // IDLE wipes the playfield but keeps the LFSR running across games.
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      cnt_d    = '0;
      grid_d   = '0;
      score_d  = '0;
      misses_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      grid_q   <= '0;
      lfsr_q   <= 8'hA5;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      grid_q   <= grid_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  assign tick      = tick_q;
  assign grid      = grid_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = (state_q == S_OVER);

endmodule
